instr_fetch_unit: RTL and testbench

Instruction fetch stage of the 8-bit CPU, sitting directly upstream of the control unit. It owns the program counter and requests instruction words from instruction memory over a request/valid handshake. It registers each returned word and presents its 4-bit opcode (plus operand field and PC) to the control unit and decode path over a valid/ready handshake. It accepts PC redirects (taken JUMP) from downstream and discards any stale in-flight fetch.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/instr_fetch_unit.sv | 113 +++++++++++
 tb/tb_instr_fetch_unit.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings and the fetch-stage state type.
package cpu_pkg;

    localparam int unsigned OPCODE_W = 4;

    localparam logic [OPCODE_W-1:0] OP_ADD   = 4'b0001;
    localparam logic [OPCODE_W-1:0] OP_SUB   = 4'b0010;
    localparam logic [OPCODE_W-1:0] OP_LOAD  = 4'b0110;
    localparam logic [OPCODE_W-1:0] OP_STORE = 4'b0111;
    localparam logic [OPCODE_W-1:0] OP_JUMP  = 4'b1111;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches words from instruction memory,
// and presents opcode/operand/pc downstream; redirects drop any in-flight word.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 8,
    parameter int unsigned       INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic                         imem_req,
    output logic [ADDR_W-1:0]            imem_addr,
    input  logic                         imem_valid,
    input  logic [INSTR_W-1:0]           imem_rdata,
    output logic                         instr_valid,
    input  logic                         instr_ready,
    output logic [OPCODE_W-1:0]          opcode,
    output logic [INSTR_W-OPCODE_W-1:0]  operand,
    output logic [ADDR_W-1:0]            instr_pc,
    input  logic                         redirect,
    input  logic [ADDR_W-1:0]            redirect_pc
);

    localparam int unsigned OPERAND_W = INSTR_W - OPCODE_W;

    fetch_state_t          r_state;
    fetch_state_t          w_state_nxt;
    logic [ADDR_W-1:0]     r_pc;
    logic [ADDR_W-1:0]     w_pc_nxt;
    logic                  w_load;
    logic                  r_imem_req;
    logic                  r_instr_valid;
    logic [OPCODE_W-1:0]   r_opcode;
    logic [OPERAND_W-1:0]  r_operand;
    logic [ADDR_W-1:0]     r_instr_pc;

    // Next-state / PC selection; redirect outranks every other event.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                w_state_nxt = FETCH;
                if (redirect) begin
                    w_pc_nxt = redirect_pc;
                end
            end
            FETCH: begin
                if (redirect) begin
                    w_pc_nxt    = redirect_pc;
                    w_state_nxt = imem_valid ? FETCH : DISCARD;
                end else if (imem_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (redirect) begin
                    w_pc_nxt    = redirect_pc;
                    w_state_nxt = FETCH;
                end else if (instr_ready) begin
                    w_pc_nxt    = r_pc + ADDR_W'(1);
                    w_state_nxt = FETCH;
                end
            end
            DISCARD: begin
                if (redirect) begin
                    w_pc_nxt = redirect_pc;
                end
                // The stale response is the only one owed; once it lands, refetch.
                if (imem_valid) begin
                    w_state_nxt = FETCH;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, PC, instruction register and registered handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_pc          <= RESET_PC;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b0;
            r_opcode      <= '0;
            r_operand     <= '0;
            r_instr_pc    <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_imem_req    <= (w_state_nxt == FETCH);
            r_instr_valid <= (w_state_nxt == HOLD);
            if (w_load) begin
                r_opcode   <= imem_rdata[INSTR_W-1 -: OPCODE_W];
                r_operand  <= imem_rdata[OPERAND_W-1:0];
                r_instr_pc <= r_pc;
            end
        end
    end

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_pc;
    assign instr_valid = r_instr_valid;
    assign opcode      = r_opcode;
    assign operand     = r_operand;
    assign instr_pc    = r_instr_pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model of the fetch stage.
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_valid;
    logic [15:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  opcode;
    logic [11:0] operand;
    logic [7:0]  instr_pc;
    logic        redirect;
    logic [7:0]  redirect_pc;

    int n_tests;
    int n_fail;

    instr_fetch_unit #(
        .ADDR_W   (8),
        .INSTR_W  (16),
        .RESET_PC (8'h00)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_valid  (imem_valid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .opcode      (opcode),
        .operand     (operand),
        .instr_pc    (instr_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction memory contents and a variable-latency responder.
    logic [15:0] mem [256];
    logic        mem_busy;
    int          mem_cnt;
    logic [7:0]  mem_addr;
    int          lat_fix;

    // Reference model: "waiting for start", "holding an instruction",
    // "owed a stale word", otherwise fetching at m_pc.
    logic        m_start;
    logic        m_hold;
    logic        m_stale;
    logic [7:0]  m_pc;
    logic [3:0]  e_opcode;
    logic [11:0] e_operand;
    logic [7:0]  e_ipc;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_start   <= 1'b1;
            m_hold    <= 1'b0;
            m_stale   <= 1'b0;
            m_pc      <= 8'h00;
            e_opcode  <= 4'h0;
            e_operand <= 12'h000;
            e_ipc     <= 8'h00;
        end else if (m_start) begin
            m_start <= 1'b0;
            if (redirect) m_pc <= redirect_pc;
        end else if (m_hold) begin
            if (redirect) begin
                m_hold <= 1'b0;
                m_pc   <= redirect_pc;
            end else if (instr_ready) begin
                m_hold <= 1'b0;
                m_pc   <= m_pc + 8'd1;
            end
        end else if (m_stale) begin
            if (redirect) m_pc <= redirect_pc;
            if (imem_valid) m_stale <= 1'b0;
        end else begin
            if (redirect) begin
                m_pc <= redirect_pc;
                if (!imem_valid) m_stale <= 1'b1;
            end else if (imem_valid) begin
                e_opcode  <= imem_rdata[15:12];
                e_operand <= imem_rdata[11:0];
                e_ipc     <= m_pc;
                m_hold    <= 1'b1;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        chk("imem_req", {31'd0, imem_req}, {31'd0, (!m_start && !m_hold && !m_stale)});
        if (!m_start && !m_hold && !m_stale)
            chk("imem_addr", {24'd0, imem_addr}, {24'd0, m_pc});
        chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_hold});
        chk("opcode", {28'd0, opcode}, {28'd0, e_opcode});
        chk("operand", {20'd0, operand}, {20'd0, e_operand});
        chk("instr_pc", {24'd0, instr_pc}, {24'd0, e_ipc});
    end

    // Advance to mid-cycle and produce this cycle's memory response.
    task automatic step();
        logic responded;
        @(negedge clk);
        #1;
        responded  = 1'b0;
        imem_valid = 1'b0;
        imem_rdata = 16'($urandom);
        if (reset) begin
            mem_busy = 1'b0;
        end else begin
            if (mem_busy) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    imem_valid = 1'b1;
                    imem_rdata = mem[mem_addr];
                    mem_busy   = 1'b0;
                    responded  = 1'b1;
                end
            end
            if (!responded && !mem_busy && imem_req) begin
                mem_busy = 1'b1;
                mem_addr = imem_addr;
                mem_cnt  = (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 3));
            end
        end
    endtask

    task automatic drv(input logic rdy, input logic rd, input logic [7:0] rpc);
        instr_ready = rdy;
        redirect    = rd;
        redirect_pc = rpc;
    endtask

    task automatic wait_hold(input string name);
        int k;
        k = 0;
        step();
        while (!instr_valid && k < 20) begin
            drv(1'b0, 1'b0, 8'h00);
            step();
            k++;
        end
        if (!instr_valid) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        int n_disc;
        logic saw_valid;
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b1;
        imem_valid = 1'b0;
        imem_rdata = 16'h0000;
        mem_busy = 1'b0;
        mem_cnt = 0;
        mem_addr = 8'h00;
        lat_fix = 1;
        drv(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h1ABC;

        repeat (3) step();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_opcode", {28'd0, opcode}, 32'd0);
        reset = 1'b0;

        // First fetch with 1-cycle memory
        step(); drv(1'b0, 1'b0, 8'h00);
        chk("c1_req", {31'd0, imem_req}, 32'd1);
        chk("c1_addr", {24'd0, imem_addr}, 32'h00);
        step(); drv(1'b0, 1'b0, 8'h00);
        chk("c2_valid", {31'd0, instr_valid}, 32'd0);
        step(); drv(1'b0, 1'b0, 8'h00);
        chk("c3_valid", {31'd0, instr_valid}, 32'd1);
        chk("c3_opcode", {28'd0, opcode}, 32'h1);
        chk("c3_operand", {20'd0, operand}, 32'hABC);
        chk("c3_ipc", {24'd0, instr_pc}, 32'h00);

        // Backpressure: five cycles of ready=0 in total
        repeat (4) begin
            step(); drv(1'b0, 1'b0, 8'h00);
            chk("bp_req", {31'd0, imem_req}, 32'd0);
            chk("bp_valid", {31'd0, instr_valid}, 32'd1);
            chk("bp_operand", {20'd0, operand}, 32'hABC);
        end
        step(); drv(1'b1, 1'b0, 8'h00);
        step(); drv(1'b0, 1'b0, 8'h00);
        chk("next_addr", {24'd0, imem_addr}, 32'h01);
        chk("next_valid", {31'd0, instr_valid}, 32'd0);

        // Redirect in HOLD with ready=1 the same cycle
        wait_hold("hold1");
        drv(1'b1, 1'b1, 8'h40);
        step(); drv(1'b0, 1'b0, 8'h00);
        chk("rdh_valid", {31'd0, instr_valid}, 32'd0);
        chk("rdh_req", {31'd0, imem_req}, 32'd1);
        chk("rdh_addr", {24'd0, imem_addr}, 32'h40);
        wait_hold("hold40");
        chk("rdh_ipc", {24'd0, instr_pc}, 32'h40);

        // Redirect during FETCH with 3-cycle memory
        lat_fix = 3;
        drv(1'b1, 1'b0, 8'h00);
        step();
        chk("rdf_addr", {24'd0, imem_addr}, 32'h41);
        drv(1'b0, 1'b1, 8'h20);
        n_disc = 0;
        saw_valid = 1'b0;
        step();
        while (!imem_req && n_disc < 10) begin
            if (instr_valid) saw_valid = 1'b1;
            drv(1'b0, 1'b0, 8'h00);
            n_disc++;
            step();
        end
        drv(1'b0, 1'b0, 8'h00);
        chk("rdf_disc_cycles", n_disc, 32'd3);
        chk("rdf_no_stale", {31'd0, saw_valid}, 32'd0);
        chk("rdf_addr2", {24'd0, imem_addr}, 32'h20);
        lat_fix = 1;
        wait_hold("hold20");
        chk("rdf_ipc", {24'd0, instr_pc}, 32'h20);
        chk("rdf_operand", {20'd0, operand}, {20'd0, mem[8'h20][11:0]});

        // Redirect coincident with imem_valid goes straight to FETCH
        drv(1'b1, 1'b0, 8'h00);
        step(); drv(1'b0, 1'b0, 8'h00);
        step();
        chk("coinc_mem", {31'd0, imem_valid}, 32'd1);
        drv(1'b0, 1'b1, 8'h77);
        step(); drv(1'b0, 1'b0, 8'h00);
        chk("coinc_req", {31'd0, imem_req}, 32'd1);
        chk("coinc_addr", {24'd0, imem_addr}, 32'h77);
        chk("coinc_valid", {31'd0, instr_valid}, 32'd0);
        wait_hold("hold77");
        chk("coinc_ipc", {24'd0, instr_pc}, 32'h77);

        // PC wrap 0xFF -> 0x00
        drv(1'b0, 1'b1, 8'hFF);
        wait_hold("holdff");
        chk("wrap_ipc", {24'd0, instr_pc}, 32'hFF);
        drv(1'b1, 1'b0, 8'h00);
        step(); drv(1'b0, 1'b0, 8'h00);
        chk("wrap_addr", {24'd0, imem_addr}, 32'h00);

        // Asynchronous reset mid-cycle in HOLD
        wait_hold("hold00");
        chk("pre_rst_opcode", {28'd0, opcode}, 32'h1);
        drv(1'b0, 1'b0, 8'h00);
        #1 reset = 1'b1;
        #1;
        chk("arst_valid", {31'd0, instr_valid}, 32'd0);
        chk("arst_req", {31'd0, imem_req}, 32'd0);
        chk("arst_opcode", {28'd0, opcode}, 32'd0);
        step();
        step();
        reset = 1'b0;
        step(); drv(1'b0, 1'b0, 8'h00);
        chk("arst_restart_req", {31'd0, imem_req}, 32'd1);
        chk("arst_restart_addr", {24'd0, imem_addr}, 32'h00);

        // Randomized traffic
        lat_fix = 0;
        repeat (3000) begin
            logic rd;
            step();
            rd = ($urandom_range(0, 9) == 0) && !(m_stale && imem_valid);
            drv(($urandom_range(0, 3) != 0), rd, 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
